// File: rtl/can_det_pkg.sv
// rtl/can_det_pkg.sv - shared types, widths and helpers for the CAN detection scheduler
package can_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int CLASS_W = 2;
  localparam int NODE_W  = 9;
  localparam int DEPTH_W = 5;
  localparam int CNT_W   = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/can_rr_arbiter.sv
// rtl/can_rr_arbiter.sv - combinational round-robin pick starting after the last granted channel
module can_rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [IDX_W-1:0] idx;

  // Scan ptr+1, ptr+2, ... (wrapping) and take the first requester found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (en && !grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_detect_scheduler.sv
// rtl/can_detect_scheduler.sv - shares one detection engine among CAN channels with watchdog and tagged results
module can_detect_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int FEAT_W      = 64,
  parameter int TIMEOUT_CYC = 1000,
  parameter int NODE_W      = 9,
  parameter int DEPTH_W     = 5,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CH-1:0]                   req_valid,
  input  logic [NUM_CH*FEAT_W-1:0]            req_feat,
  output logic [NUM_CH-1:0]                   req_ready,
  output logic                                det_start,
  output logic [FEAT_W-1:0]                   det_feat,
  input  logic                                det_done,
  input  logic                                det_is_attack,
  input  logic [can_det_pkg::CLASS_W-1:0]     det_class,
  input  logic [NODE_W-1:0]                   det_node,
  input  logic [DEPTH_W-1:0]                  det_depth,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [CH_W-1:0]                     res_ch,
  output logic                                res_is_attack,
  output logic [can_det_pkg::CLASS_W-1:0]     res_class,
  output logic [NODE_W-1:0]                   res_node,
  output logic [DEPTH_W-1:0]                  res_depth,
  output logic                                res_timeout,
  output logic                                busy,
  output logic [can_det_pkg::CNT_W-1:0]       attack_cnt,
  output logic [can_det_pkg::CNT_W-1:0]       timeout_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  can_det_pkg::state_e state_q;
  logic [CH_W-1:0]     ptr_q;
  logic [TMR_W-1:0]    timer_q;
  logic [FEAT_W-1:0]   feat_q;
  logic [CH_W-1:0]     ch_q;
  logic                start_q;
  logic                valid_q;
  logic                busy_q;
  logic                is_attack_q;
  logic [can_det_pkg::CLASS_W-1:0] class_q;
  logic [NODE_W-1:0]   node_q;
  logic [DEPTH_W-1:0]  depth_q;
  logic                timeout_q;
  logic [can_det_pkg::CNT_W-1:0] attack_cnt_q, attack_cnt_d;
  logic [can_det_pkg::CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

  logic [NUM_CH-1:0]   gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_any;

  // Requests are only considered while idle, so req_ready is a single-cycle accept strobe.
  can_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (state_q == can_det_pkg::IDLE),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign attack_cnt_d  = can_det_pkg::sat_inc(attack_cnt_q);
  assign timeout_cnt_d = can_det_pkg::sat_inc(timeout_cnt_q);

  // Job lifecycle: accept, pulse start, wait on engine or watchdog, hold result until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= can_det_pkg::IDLE;
      ptr_q         <= CH_W'(NUM_CH - 1);
      timer_q       <= '0;
      feat_q        <= '0;
      ch_q          <= '0;
      start_q       <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      is_attack_q   <= 1'b0;
      class_q       <= '0;
      node_q        <= '0;
      depth_q       <= '0;
      timeout_q     <= 1'b0;
      attack_cnt_q  <= '0;
      timeout_cnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        can_det_pkg::IDLE: begin
          if (gnt_any) begin
            feat_q  <= req_feat[int'(gnt_idx)*FEAT_W +: FEAT_W];
            ch_q    <= gnt_idx;
            ptr_q   <= gnt_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= can_det_pkg::START;
          end
        end
        can_det_pkg::START: begin
          timer_q <= '0;
          state_q <= can_det_pkg::WAIT;
        end
        can_det_pkg::WAIT: begin
          // A completion in the expiry cycle still delivers the engine's answer.
          if (det_done) begin
            is_attack_q <= det_is_attack;
            class_q     <= det_class;
            node_q      <= det_node;
            depth_q     <= det_depth;
            timeout_q   <= 1'b0;
            valid_q     <= 1'b1;
            state_q     <= can_det_pkg::RESP;
          end else if (timer_q == TMR_LAST) begin
            is_attack_q   <= 1'b0;
            class_q       <= '0;
            node_q        <= '0;
            depth_q       <= '0;
            timeout_q     <= 1'b1;
            valid_q       <= 1'b1;
            timeout_cnt_q <= timeout_cnt_d;
            state_q       <= can_det_pkg::RESP;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        can_det_pkg::RESP: begin
          if (res_ready) begin
            if (is_attack_q && !timeout_q) begin
              attack_cnt_q <= attack_cnt_d;
            end
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= can_det_pkg::IDLE;
          end
        end
        default: state_q <= can_det_pkg::IDLE;
      endcase
    end
  end

  assign req_ready     = gnt;
  assign det_start     = start_q;
  assign det_feat      = feat_q;
  assign res_valid     = valid_q;
  assign res_ch        = ch_q;
  assign res_is_attack = is_attack_q;
  assign res_class     = class_q;
  assign res_node      = node_q;
  assign res_depth     = depth_q;
  assign res_timeout   = timeout_q;
  assign busy          = busy_q;
  assign attack_cnt    = attack_cnt_q;
  assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_can_detect_scheduler.sv
// tb/tb_can_detect_scheduler.sv - self-checking bench for can_detect_scheduler
module tb_can_detect_scheduler;

  localparam int NUM_CH = 4;
  localparam int FEAT_W = 64;
  localparam int TO     = 20;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [255:0] req_feat;
  logic [3:0]   req_ready;
  logic         det_start;
  logic [63:0]  det_feat;
  logic         det_done;
  logic         det_is_attack;
  logic [1:0]   det_class;
  logic [8:0]   det_node;
  logic [4:0]   det_depth;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_ch;
  logic         res_is_attack;
  logic [1:0]   res_class;
  logic [8:0]   res_node;
  logic [4:0]   res_depth;
  logic         res_timeout;
  logic         busy;
  logic [15:0]  attack_cnt;
  logic [15:0]  timeout_cnt;

  int total = 0;
  int bad   = 0;

  int eng_n   = 5;
  int eng_cnt = 0;
  bit eng_on  = 1'b1;

  int m_ptr = NUM_CH - 1;
  int m_att = 0;
  int m_to  = 0;

  can_detect_scheduler #(
    .NUM_CH(NUM_CH), .FEAT_W(FEAT_W), .TIMEOUT_CYC(TO), .NODE_W(9), .DEPTH_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_feat(req_feat), .req_ready(req_ready),
    .det_start(det_start), .det_feat(det_feat), .det_done(det_done),
    .det_is_attack(det_is_attack), .det_class(det_class), .det_node(det_node), .det_depth(det_depth),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_is_attack(res_is_attack), .res_class(res_class), .res_node(res_node), .res_depth(res_depth),
    .res_timeout(res_timeout), .busy(busy), .attack_cnt(attack_cnt), .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: pulses det_done eng_n cycles after it sees det_start (never if eng_on=0).
  initial begin
    det_done = 1'b0;
    forever begin
      @(negedge clk);
      det_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && eng_on) det_done = 1'b1;
      end
      if (det_start === 1'b1) eng_cnt = eng_n;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_grant(input logic [3:0] m, input int p);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (m[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic rand_feat();
    for (int i = 0; i < NUM_CH; i++) req_feat[i*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic rand_eng();
    det_is_attack = 1'($urandom_range(0, 1));
    det_class     = 2'($urandom);
    det_node      = 9'($urandom);
    det_depth     = 5'($urandom);
  endtask

  // One job from accept to handshake, checked against the expected grant, latency and result.
  task automatic do_job(input string nm, input logic [3:0] vmask, input int n, input bit on, input int hold);
    int g;
    int lat;
    bit ok;
    bit e_to;
    logic [63:0] efeat;
    logic e_att;
    logic [1:0] e_cls;
    logic [8:0] e_node;
    logic [4:0] e_dep;
    @(negedge clk);
    eng_n = n; eng_on = on; req_valid = vmask; res_ready = 1'b0;
    #1;
    g     = next_grant(vmask, m_ptr);
    m_ptr = g;
    efeat = req_feat[g*64 +: 64];
    e_to  = !on || (n > TO);
    e_att = e_to ? 1'b0 : det_is_attack;
    e_cls = e_to ? 2'd0 : det_class;
    e_node = e_to ? 9'd0 : det_node;
    e_dep = e_to ? 5'd0 : det_depth;
    chk({nm, ".grant"}, req_ready, 64'd1 << g);
    @(negedge clk);
    chk({nm, ".start"}, {det_start, req_ready, busy}, {1'b1, 4'b0, 1'b1});
    chk({nm, ".det_feat"}, det_feat, efeat);
    req_valid = 4'($urandom);
    lat = 0; ok = 1'b1;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (det_start !== 1'b0 || req_ready !== 4'b0) ok = 1'b0;
      if (res_valid === 1'b1) break;
    end
    chk({nm, ".latency"}, lat, e_to ? TO + 1 : n + 1);
    chk({nm, ".res"}, {res_ch, res_timeout, res_is_attack, res_class, res_node, res_depth},
        {2'(g), e_to, e_att, e_cls, e_node, e_dep});
    if (e_to) m_to++;
    else if (e_att) m_att++;
    repeat (hold) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      if (req_ready !== 4'b0 || det_start !== 1'b0 || res_valid !== 1'b1 || det_feat !== efeat ||
          {res_ch, res_timeout, res_is_attack, res_class, res_node, res_depth} !==
          {2'(g), e_to, e_att, e_cls, e_node, e_dep}) ok = 1'b0;
    end
    chk({nm, ".quiet"}, ok, 1);
    res_ready = 1'b1; req_valid = 4'b0;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, ".idle"}, {busy, res_valid, req_ready}, 0);
    chk({nm, ".attack_cnt"}, attack_cnt, m_att);
    chk({nm, ".timeout_cnt"}, timeout_cnt, m_to);
  endtask

  initial begin
    int okq;
    rst_n = 1'b0; req_valid = 4'b0; res_ready = 1'b0;
    req_feat = '0;
    det_is_attack = 1'b0; det_class = 2'd0; det_node = 9'd0; det_depth = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ctl", {busy, res_valid, det_start, req_ready}, 0);
    chk("rst.data", {res_ch, res_timeout, res_is_attack, res_class, res_node, res_depth}, 0);
    chk("rst.feat", det_feat, 0);
    chk("rst.cnt", {attack_cnt, timeout_cnt}, 0);
    rst_n = 1'b1;

    // Single request on ch0 with fixed engine answer
    rand_feat();
    req_feat[63:0] = 64'hA5;
    det_is_attack = 1'b1; det_class = 2'b10; det_node = 9'd37; det_depth = 5'd6;
    do_job("single", 4'b0001, 10, 1'b1, 0);

    // Fairness with every channel requesting
    for (int i = 0; i < 8; i++) begin
      rand_feat(); rand_eng();
      do_job("fair", 4'hF, 3, 1'b1, 0);
    end

    // Random masks, engine latencies and consumer stalls
    for (int i = 0; i < 12; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      rand_feat(); rand_eng();
      do_job("rand", m, $urandom_range(1, TO), ($urandom_range(0, 4) != 0), $urandom_range(0, 3));
    end

    // Watchdog expiry; the attack verdict must not count
    rand_feat(); det_is_attack = 1'b1; det_class = 2'd3; det_node = 9'h1FF; det_depth = 5'h1F;
    do_job("timeout", 4'($urandom_range(1, 15)), 5, 1'b0, 0);

    // Long consumer backpressure
    rand_feat(); rand_eng();
    do_job("backpr", 4'($urandom_range(1, 15)), 7, 1'b1, 50);

    // Completion in the expiry cycle
    rand_feat(); det_is_attack = 1'b1; det_class = 2'd1; det_node = 9'd200; det_depth = 5'd17;
    do_job("race", 4'hF, TO, 1'b1, 0);

    // Reset while waiting on the engine
    @(negedge clk);
    eng_n = 15; eng_on = 1'b1; req_valid = 4'b0100; res_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0;
    chk("midrst.start", det_start, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.state", {busy, res_valid, det_start}, 0);
    chk("midrst.cnt", {attack_cnt, timeout_cnt}, 0);
    okq = 1;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) okq = 0;
    end
    chk("midrst.late_done", okq, 1);
    m_ptr = NUM_CH - 1; m_att = 0; m_to = 0;
    rand_feat(); rand_eng();
    do_job("postrst", 4'hF, 4, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
